alu1_seq: RTL

Multi-cycle operation sequencer that drives the command side of the shared 4-bit-command ALU. It issues one ALU command per cycle and consumes the ALU's `out`/`co`. It accepts requests over a valid/ready handshake and returns results over a second one. Supported operations are a single raw ALU command, unsigned shift-add multiply, and unsigned restoring divide. It sits between the execute-stage issue logic and the one combinational ALU instance, which the parent owns.

---
 rtl/alu1_pkg.sv | 36 +++
 rtl/alu1_seq_step.sv | 61 ++++++
 rtl/alu1_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu1_pkg.sv
// Shared definitions for the 4-bit-command ALU and the operation sequencer
// that drives it.
//   - ALU command codes (ALU_CMD_W bits wide)
//   - seq_op_e    : operation select of the sequencer request port
//   - seq_state_e : sequencer control state
package alu1_pkg;

    localparam int ALU_CMD_W = 4;

    localparam logic [ALU_CMD_W-1:0] TRANSFER   = 4'd0;
    localparam logic [ALU_CMD_W-1:0] INC        = 4'd1;
    localparam logic [ALU_CMD_W-1:0] ADD        = 4'd2;
    localparam logic [ALU_CMD_W-1:0] ADD_PLUS1  = 4'd3;
    localparam logic [ALU_CMD_W-1:0] SUB_MINUS1 = 4'd4;
    localparam logic [ALU_CMD_W-1:0] SUB        = 4'd5;
    localparam logic [ALU_CMD_W-1:0] DEC        = 4'd6;
    localparam logic [ALU_CMD_W-1:0] TRANSFER2  = 4'd7;
    localparam logic [ALU_CMD_W-1:0] AND        = 4'd8;
    localparam logic [ALU_CMD_W-1:0] OR         = 4'd9;
    localparam logic [ALU_CMD_W-1:0] XOR        = 4'd10;
    localparam logic [ALU_CMD_W-1:0] NOT        = 4'd11;

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        MULU = 2'd1,
        DIVU = 2'd2,
        RSVD = 2'd3
    } seq_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu1_seq_step.sv
// One iteration of shift-add multiply or restoring divide.
// Produces the ALU command/operands for the current step and, from the ALU's
// combinational answer, the next {hi, lo} (multiply) or {rem, quo} (divide).
// Ports:
//   is_div            : 1 = divide step, 0 = multiply step
//   hi, lo, aux       : hi/rem, lo/quo, multiplicand/divisor registers
//   alu_out, alu_co   : ALU result for the operands driven this cycle
//   step_cmd/in1/in2  : ALU command and operands for this step
//   hi_nxt, lo_nxt    : register values after this step
module alu1_seq_step
    import alu1_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     hi,
    input  logic [WIDTH-1:0]     lo,
    input  logic [WIDTH-1:0]     aux,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_co,
    output logic [ALU_CMD_W-1:0] step_cmd,
    output logic [WIDTH-1:0]     step_in1,
    output logic [WIDTH-1:0]     step_in2,
    output logic [WIDTH-1:0]     hi_nxt,
    output logic [WIDTH-1:0]     lo_nxt
);

    // Partial remainder shifted left by one with the next dividend bit.
    logic [WIDTH-1:0] r_shift;
    // The bit shifted out of rem is the implicit (WIDTH+1)th bit of the
    // partial remainder; when set, the subtraction always succeeds even
    // though the WIDTH-bit ALU reports a borrow.
    logic             take;

    assign r_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign take    = alu_co | hi[WIDTH-1];

    always_comb begin
        step_cmd = TRANSFER;
        step_in1 = hi;
        step_in2 = '0;
        hi_nxt   = hi;
        lo_nxt   = lo;
        if (is_div) begin
            step_cmd = SUB;
            step_in1 = r_shift;
            step_in2 = aux;
            hi_nxt   = take ? alu_out : r_shift;
            lo_nxt   = {lo[WIDTH-2:0], take};
        end else begin
            if (lo[0]) begin
                step_cmd = ADD;
                step_in2 = aux;
            end
            // {c, alu_out, lo} >> 1; carry only counts on an ADD step.
            hi_nxt = {lo[0] & alu_co, alu_out[WIDTH-1:1]};
            lo_nxt = {alu_out[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu1_seq.sv
// Multi-cycle operation sequencer in front of the shared combinational ALU.
// Issues one ALU command per cycle; supports a raw ALU command, unsigned
// multiply (WIDTH steps) and unsigned restoring divide (WIDTH steps).
// Ports:
//   clk, rst                     : clock, async active-high reset
//   req_valid/ready, req_op,
//   req_cmd, req_a, req_b        : request handshake and payload
//   rsp_valid/ready, rsp_lo,
//   rsp_hi, rsp_co, rsp_err      : response handshake and payload
//   alu_cmd, alu_in1, alu_in2    : command side of the external ALU
//   alu_out, alu_co              : combinational ALU result
//   alu_busy                     : ALU result consumed this cycle
module alu1_seq
    import alu1_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ALU_CMD_W-1:0] req_cmd,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_lo,
    output logic [WIDTH-1:0]     rsp_hi,
    output logic                 rsp_co,
    output logic                 rsp_err,
    output logic [ALU_CMD_W-1:0] alu_cmd,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_co,
    output logic                 alu_busy
);

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    seq_state_e            state, state_nxt;
    seq_op_e               op;
    logic [ALU_CMD_W-1:0]  cmd;
    logic [CW-1:0]         cnt;
    // hi/lo double as the response registers once the operation completes.
    logic [WIDTH-1:0]      hi, lo, aux;
    logic                  co, err;
    logic                  last_step;

    logic [ALU_CMD_W-1:0]  step_cmd;
    logic [WIDTH-1:0]      step_in1, step_in2, hi_nxt, lo_nxt;

    alu1_seq_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op == DIVU),
        .hi       (hi),
        .lo       (lo),
        .aux      (aux),
        .alu_out  (alu_out),
        .alu_co   (alu_co),
        .step_cmd (step_cmd),
        .step_in1 (step_in1),
        .step_in2 (step_in2),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    assign last_step = (op == ALU) ? (cnt == '0) : (cnt == LAST_STEP);

    // Ready is forced low while reset is held, not just after it.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);
    assign rsp_lo    = lo;
    assign rsp_hi    = hi;
    assign rsp_co    = co;
    assign rsp_err   = err;

    always_comb begin
        state_nxt = state;
        alu_cmd   = TRANSFER;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = (seq_op_e'(req_op) == RSVD) ? DONE : EXEC;
            end
            EXEC: begin
                alu_busy = 1'b1;
                if (op == ALU) begin
                    alu_cmd = cmd;
                    alu_in1 = lo;
                    alu_in2 = aux;
                end else begin
                    alu_cmd = step_cmd;
                    alu_in1 = step_in1;
                    alu_in2 = step_in2;
                end
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op    <= ALU;
            cmd   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            aux   <= '0;
            co    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op  <= seq_op_e'(req_op);
                        cmd <= req_cmd;
                        cnt <= '0;
                        hi  <= '0;
                        co  <= 1'b0;
                        if (seq_op_e'(req_op) == RSVD) begin
                            lo  <= '0;
                            aux <= '0;
                            err <= 1'b1;
                        end else begin
                            lo  <= req_a;
                            aux <= req_b;
                            err <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (op == ALU) begin
                        lo <= alu_out;
                        hi <= '0;
                        co <= alu_co;
                    end else begin
                        hi <= hi_nxt;
                        lo <= lo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
